// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, sequences imem req/ack fetches and holds instr for decode.
// Optional fetch watchdog (sticky fetch_err) is enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer #(
    parameter int NUM_BITS_ADDR_BARRAMENTO = 32,
    parameter int NUM_BITS_ADDR_PROG       = 8,
    parameter int TIMEOUT_CYCLES           = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                stall,
    input  logic                                branch_taken,
    input  logic [NUM_BITS_ADDR_BARRAMENTO-1:0] sign_imm,
    input  logic                                jump,
    input  logic [NUM_BITS_ADDR_BARRAMENTO-1:0] jump_target,
    output logic                                imem_req,
    output logic [NUM_BITS_ADDR_BARRAMENTO-1:0] imem_addr,
    input  logic                                imem_ack,
    input  logic [NUM_BITS_ADDR_BARRAMENTO-1:0] imem_rdata,
    output logic [NUM_BITS_ADDR_BARRAMENTO-1:0] pc,
    output logic [NUM_BITS_ADDR_BARRAMENTO-1:0] instr,
    output logic                                instr_valid,
    output logic                                fetch_err
);

    localparam int W = NUM_BITS_ADDR_BARRAMENTO;
    localparam logic [W-1:0] PC_MAX = W'(2 ** NUM_BITS_ADDR_PROG - 4);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         timeout;
    logic [W-1:0] pc_seq;
    logic [W-1:0] pc_raw;
    logic [W-1:0] next_pc;
    logic         unused_jt_bits;

    assign unused_jt_bits = ^jump_target[1:0];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: defaults first so every path assigns state_next and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (imem_ack || timeout) state_next = ISSUE;
            ISSUE:   if (!stall) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Jump beats branch; any result outside the program window (incl. negative) restarts at 0.
    always_comb begin
        pc_seq = pc + W'(4);
        pc_raw = pc_seq;
        if (jump)              pc_raw = {jump_target[W-1:2], 2'b00};
        else if (branch_taken) pc_raw = pc_seq + (sign_imm << 2);
        next_pc = (pc_raw > PC_MAX) ? '0 : pc_raw;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            instr <= '0;
        end else begin
            if (state == FETCH) begin
                if (imem_ack)     instr <= imem_rdata;
                else if (timeout) instr <= '0;
            end
            if (state == ISSUE && !stall) pc <= next_pc;
        end
    end

    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == ISSUE);
    assign imem_addr   = pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    // An ack arriving on the timeout cycle wins: real data, no error.
    assign timeout = (state == FETCH) && !imem_ack && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state != FETCH) wd_cnt <= '0;
            else if (!imem_ack) wd_cnt <= wd_cnt + CNT_W'(1);
            if (timeout) err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

endmodule
